// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: default widths, instruction field layout,
// fetch-relevant opcodes and the fetch stage state encoding.
package cpu_pkg;

    localparam int unsigned CPU_PC_W  = 4;
    localparam int unsigned CPU_INS_W = 9;

    // Instruction layout: opcode [8:5], bit 4 unused by fetch, operand [3:0]
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned OPR_W   = 4;
    localparam int unsigned OPR_LSB = 0;

    localparam logic [OPC_W-1:0] OP_JZ   = 4'hD;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC resolver: decodes jump/halt opcodes from the fetched
// instruction and selects between the jump target and the sequential PC.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = CPU_PC_W,
    parameter int unsigned INS_W = CPU_INS_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [INS_W-1:0] ins_in,
    input  logic             zero_flag,
    output logic [PC_W-1:0]  next_pc_c,
    output logic             take_jump_c,
    output logic             is_halt_c
);

    logic [OPC_W-1:0] opcode;
    logic [OPR_W-1:0] operand;
    logic             unused_ins;

    assign opcode   = ins_in[OPC_LSB +: OPC_W];
    assign operand  = ins_in[OPR_LSB +: OPR_W];
    // Bits outside the opcode/operand fields are decode's business, not ours
    assign unused_ins = ^ins_in;

    always_comb begin
        take_jump_c = 1'b0;
        is_halt_c   = 1'b0;
        case (opcode)
            OP_JMP:  take_jump_c = 1'b1;
            OP_JZ:   take_jump_c = zero_flag;
            OP_HALT: is_halt_c   = 1'b1;
            default: take_jump_c = 1'b0;
        endcase
    end

    // Sequential increment wraps naturally at 2^PC_W
    assign next_pc_c = take_jump_c ? PC_W'(operand) : pc + PC_W'(1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches instructions from ins_mem into ir,
// and resolves jumps and halt so downstream sees one instruction per cycle.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned      PC_W     = CPU_PC_W,
    parameter int unsigned      INS_W    = CPU_INS_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             zero_flag,
    input  logic [INS_W-1:0] ins_in,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] ir,
    output logic             ir_valid,
    output logic             jump_taken,
    output logic             halted
);

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [PC_W-1:0]  pc_d;
    logic [INS_W-1:0] ir_d;
    logic             ir_valid_d;
    logic             jump_taken_d;
    logic             halted_d;

    logic [PC_W-1:0]  next_pc_c;
    logic             take_jump_c;
    logic             is_halt_c;

    fetch_next_pc #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_next_pc (
        .pc          (pc),
        .ins_in      (ins_in),
        .zero_flag   (zero_flag),
        .next_pc_c   (next_pc_c),
        .take_jump_c (take_jump_c),
        .is_halt_c   (is_halt_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            ir_valid   <= 1'b0;
            jump_taken <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            ir         <= ir_d;
            ir_valid   <= ir_valid_d;
            jump_taken <= jump_taken_d;
            halted     <= halted_d;
        end
    end

    // Next-state and next-output logic; issue flags are single-cycle pulses
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        ir_d         = ir;
        ir_valid_d   = 1'b0;
        jump_taken_d = 1'b0;
        halted_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!stall) begin
                    ir_d       = ins_in;
                    ir_valid_d = 1'b1;
                    if (is_halt_c) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d         = next_pc_c;
                        jump_taken_d = take_jump_c;
                    end
                end
            end
            ST_HALT: begin
                // halted rises one edge after the HALT instruction is issued
                halted_d = 1'b1;
                if (start) begin
                    state_d  = ST_FETCH;
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 4-bit CPU, sitting directly upstream of `ins_mem`.
- Owns the program counter and drives it to `ins_mem` as the read address.
- Captures the 9-bit instruction `ins_mem` returns (combinationally, same cycle) into an instruction register for decode/execute.
- Resolves jumps and halt locally, so downstream stages see one instruction per cycle with no redirect logic of their own.

## Interface
Parameters:
- `PC_W`, 4, program counter width (16-entry instruction memory)
- `INS_W`, 9, instruction width
- `RESET_PC`, 0, PC value after reset and on restart

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin/restart execution; level, sampled at each clock edge
- `stall`  in  1  downstream not ready; freezes the fetch stage
- `zero_flag`  in  1  ALU zero flag from execute, used by JZ
- `ins_in`  in  INS_W  instruction from `ins_mem` at address `pc`
- `pc`  out  PC_W  current fetch address to `ins_mem`
- `ir`  out  INS_W  latched instruction
- `ir_valid`  out  1  `ir` holds a newly issued instruction this cycle
- `jump_taken`  out  1  the instruction in `ir` redirected the PC; asserts only together with `ir_valid`
- `halted`  out  1  stage is in HALT

## Operation
Instruction fields: opcode `ins_in[8:5]`, operand `ins_in[3:0]`. Bit 4 is ignored by this block.

Fetch-relevant opcodes:
- `OP_JMP` = 4'hE: unconditional jump, target = operand.
- `OP_JZ` = 4'hD: jump to operand if `zero_flag` = 1, otherwise fall through.
- `OP_HALT` = 4'hF: stop fetching.
- All other opcodes: sequential.

State machine:
- **IDLE** (reset state)
  - `start` = 1 → FETCH.
- **FETCH**, on each edge:
  - `stall` = 1: `pc` and `ir` hold; `ir_valid` <= 0; `jump_taken` <= 0.
  - `stall` = 0, normal: `ir` <= `ins_in`; `ir_valid` <= 1; `pc` <= next PC (see rules below).
  - `stall` = 0, opcode is `OP_HALT`: `ir` latches the HALT instruction with `ir_valid` = 1; `pc` holds; → HALT.
- **HALT**
  - `halted` = 1; `ir_valid` = 0; `pc` and `ir` hold.
  - `start` = 1 → FETCH with `pc` <= `RESET_PC`.

Next-PC rules:
- Sequential next PC is `pc + 1` mod 2^PC_W, so 15 wraps to 0.
- Jump target replaces the increment.
- `jump_taken` <= 1 exactly when a JMP, or a JZ with `zero_flag` = 1, is issued.

Reset values (asynchronous, taking effect immediately on `rst_n` low):
- `pc` = `RESET_PC`, `ir` = 0, `ir_valid` = 0, `jump_taken` = 0, `halted` = 0, state = IDLE.
- Reset mid-operation discards the in-flight instruction.

Boundary conditions:
- `start` in FETCH: ignored.
- `stall` and a HALT opcode on the same edge: stall wins; the HALT is issued on the first unstalled edge.
- JMP whose target equals the current `pc` (self-loop): legal; re-issues the same instruction every cycle.
- `zero_flag` is sampled on the same edge that issues the JZ.

## Timing
- `pc` → `ins_in` is combinational; `ins_in` must settle within the cycle.
- Fetch-to-issue latency: 1 cycle (`ir` reflects `ins_mem[pc]` after the edge at which `pc` was presented).
- `start` seen at edge n: FETCH from edge n; first instruction (address `RESET_PC`) is in `ir` with `ir_valid` = 1 after edge n+1.
- Throughput: one instruction per unstalled cycle.
- Jumps: zero bubbles; the target is fetched on the cycle after the jump is issued.
- `halted` rises on the edge after the HALT instruction is issued.
- All outputs are registered except `pc`, which is the PC register output.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W` and `INS_W` defaults
  - opcode constants `OP_JMP`, `OP_JZ`, `OP_HALT`
  - opcode/operand field positions
  - the fetch state enum (IDLE, FETCH, HALT)
- One combinational sub-module, `fetch_next_pc`:
  - inputs: `pc`, `ins_in`, `zero_flag`
  - outputs: next PC, `take_jump`, `is_halt`
- `fetch_unit` holds the FSM, the PC, `ir` and the output registers.

## Test plan
- Reset, then `start` pulse with memory 0x000…0x00E sequential ops → `pc` steps 0,1,2…; `ir_valid` = 1 every cycle from edge 2; address 15 wraps to 0.
- JMP 0x1C5 (target 5) at address 3 → next `ir` is from address 5; `jump_taken` = 1 with `ir` = 0x1C5 only.
- JZ 0x1A9 at address 2 with `zero_flag` = 0 → next `pc` = 3; same with `zero_flag` = 1 → next `pc` = 9 and `jump_taken` = 1.
- `stall` held 3 cycles mid-stream → `pc`/`ir` frozen, `ir_valid` = 0 for 3 cycles, no instruction lost or duplicated.
- HALT 0x1E0 at address 4, with `stall` = 1 on its first cycle → HALT issued once after stall drops; `halted` = 1 next cycle; `pc` holds 4; `start` restarts at `pc` = 0.
- `rst_n` low mid-stream at `pc` = 7 → all outputs clear immediately; no `ir_valid` until a new `start`.
